// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory, with
// per-port lock for atomic sequences and a tagged pipeline that routes read data back.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] address_dmem,
  output logic [DW-1:0] data,
  output logic          wren,
  input  logic [DW-1:0] q_dmem
);

  typedef enum logic [1:0] {
    ST_RR    = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_push_vld;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [RD_LAT-1:0]   r_pipe_tag;
  logic                w_tail_vld;
  logic                w_tail_tag;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [DW-1:0]       r_rdata0;
  logic [DW-1:0]       r_rdata1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RR;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // A locked port keeps exclusive access; the lock is released on the first
  // edge where its lock input is low, so the other port waits one more cycle.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_LOCK0: begin
        w_gnt0 = req0;
        if (!lock0) w_state_nxt = ST_RR;
      end
      ST_LOCK1: begin
        w_gnt1 = req1;
        if (!lock1) w_state_nxt = ST_RR;
      end
      default: begin
        if (req0 && (!req1 || r_last)) w_gnt0 = 1'b1;
        else if (req1)                 w_gnt1 = 1'b1;
        if (w_gnt0) begin
          w_last_nxt = 1'b0;
          if (lock0) w_state_nxt = ST_LOCK0;
        end else if (w_gnt1) begin
          w_last_nxt = 1'b1;
          if (lock1) w_state_nxt = ST_LOCK1;
        end
      end
    endcase
    if (!reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign gnt0         = w_gnt0;
  assign gnt1         = w_gnt1;
  assign wren         = (w_gnt0 & we0) | (w_gnt1 & we1);
  assign address_dmem = w_gnt0 ? addr0  : (w_gnt1 ? addr1  : '0);
  assign data         = w_gnt0 ? wdata0 : (w_gnt1 ? wdata1 : '0);
  assign w_push_vld   = (w_gnt0 & ~we0) | (w_gnt1 & ~we1);

  // Entry i holds a read issued i+1 edges ago; the tail lines up with q_dmem.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pipe_vld <= '0;
      r_pipe_tag <= '0;
    end else begin
      r_pipe_vld[0] <= w_push_vld;
      r_pipe_tag[0] <= w_gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_tail_vld = r_pipe_vld[RD_LAT-1];
  assign w_tail_tag = r_pipe_tag[RD_LAT-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_tail_vld & ~w_tail_tag;
      r_rvalid1 <= w_tail_vld & w_tail_tag;
      if (w_tail_vld && !w_tail_tag) r_rdata0 <= q_dmem;
      if (w_tail_vld && w_tail_tag)  r_rdata1 <= q_dmem;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3) share stimulus and
// are compared every cycle to a transaction-level model, plus directed vectors.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct {
    logic          rst;
    logic          q0, w0, l0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          q1, w1, l1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eg0, eg1, erv0, erv1;
    logic [DW-1:0] erd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0 [2];
  logic          gnt1 [2];
  logic          rvalid0 [2];
  logic          rvalid1 [2];
  logic          wren [2];
  logic [DW-1:0] rdata0 [2];
  logic [DW-1:0] rdata1 [2];
  logic [DW-1:0] data_o [2];
  logic [DW-1:0] q_dmem [2];
  logic [AW-1:0] adr_o [2];

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut_l1 (
    .clock(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata0(rdata0[0]), .rdata1(rdata1[0]), .address_dmem(adr_o[0]), .data(data_o[0]),
    .wren(wren[0]), .q_dmem(q_dmem[0])
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut_l3 (
    .clock(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata0(rdata0[1]), .rdata1(rdata1[1]), .address_dmem(adr_o[1]), .data(data_o[1]),
    .wren(wren[1]), .q_dmem(q_dmem[1])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: who owns the memory, who was served last, and a
  // calendar of read returns expected per cycle.
  int            owner = -1;
  bit            last = 1'b1;
  logic [DW-1:0] ref_mem [4096];
  bit            ev [2][8];
  bit            ep [2][8];
  logic [DW-1:0] ed [2][8];
  logic [DW-1:0] hold [2][2];

  // Memory behind each DUT, updated once per cycle from the previous cycle's bus.
  logic [DW-1:0] ram [2][4096];
  logic [AW-1:0] pa [2];
  logic          pw [2];
  logic [DW-1:0] pd [2];
  logic [DW-1:0] qp0;
  logic [DW-1:0] qp1 [3];
  assign q_dmem[0] = qp0;
  assign q_dmem[1] = qp1[2];

  vec_t          tbl [19];
  logic          obs_v [8];
  logic [DW-1:0] obs_d [8];

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic vec_t mk(input logic r,
                              input logic q0, input logic w0, input logic l0,
                              input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic q1, input logic w1, input logic l1,
                              input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic eg0, input logic eg1,
                              input logic erv0, input logic erv1, input logic [DW-1:0] erd);
    vec_t v;
    v.rst = r; v.q0 = q0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.erv0 = erv0; v.erv1 = erv1; v.erd = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    int            g;
    int            s;
    int            s2;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] edat;
    bit            erv;
    if (!rst_n) begin
      owner = -1;
      last  = 1'b1;
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 8; k++) ev[i][k] = 1'b0;
        hold[i][0] = '0;
        hold[i][1] = '0;
        chk($sformatf("rst_gnt0[%0d]", i), 64'(gnt0[i]), 64'd0);
        chk($sformatf("rst_gnt1[%0d]", i), 64'(gnt1[i]), 64'd0);
        chk($sformatf("rst_wren[%0d]", i), 64'(wren[i]), 64'd0);
        chk($sformatf("rst_addr[%0d]", i), 64'(adr_o[i]), 64'd0);
        chk($sformatf("rst_data[%0d]", i), 64'(data_o[i]), 64'd0);
        chk($sformatf("rst_rvalid0[%0d]", i), 64'(rvalid0[i]), 64'd0);
        chk($sformatf("rst_rvalid1[%0d]", i), 64'(rvalid1[i]), 64'd0);
        chk($sformatf("rst_rdata0[%0d]", i), 64'(rdata0[i]), 64'd0);
        chk($sformatf("rst_rdata1[%0d]", i), 64'(rdata1[i]), 64'd0);
      end
    end else begin
      g = -1;
      if (owner >= 0) begin
        if ((owner == 0) ? req0 : req1) g = owner;
      end else if (req0 && req1) g = last ? 0 : 1;
      else if (req0) g = 0;
      else if (req1) g = 1;
      ew   = (g == 0) ? we0 : ((g == 1) ? we1 : 1'b0);
      ea   = (g == 0) ? addr0 : ((g == 1) ? addr1 : '0);
      edat = (g == 0) ? wdata0 : ((g == 1) ? wdata1 : '0);
      s = cyc % 8;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gnt0[%0d]", i), 64'(gnt0[i]), 64'(g == 0));
        chk($sformatf("gnt1[%0d]", i), 64'(gnt1[i]), 64'(g == 1));
        chk($sformatf("wren[%0d]", i), 64'(wren[i]), 64'(ew));
        chk($sformatf("address_dmem[%0d]", i), 64'(adr_o[i]), 64'(ea));
        chk($sformatf("data[%0d]", i), 64'(data_o[i]), 64'(edat));
        for (int p = 0; p < 2; p++) begin
          erv = ev[i][s] && (int'(ep[i][s]) == p);
          if (erv) hold[i][p] = ed[i][s];
          chk($sformatf("rvalid%0d[%0d]", p, i),
              64'((p == 0) ? rvalid0[i] : rvalid1[i]), 64'(erv));
          chk($sformatf("rdata%0d[%0d]", p, i),
              64'((p == 0) ? rdata0[i] : rdata1[i]), 64'(hold[i][p]));
        end
        ev[i][s] = 1'b0;
      end
      if (g >= 0) begin
        if (ew) ref_mem[ea] = edat;
        else begin
          for (int i = 0; i < 2; i++) begin
            s2 = (cyc + lat_of(i) + 1) % 8;
            ev[i][s2] = 1'b1;
            ep[i][s2] = (g == 1);
            ed[i][s2] = ref_mem[ea];
          end
        end
      end
      if (owner >= 0) begin
        if (!((owner == 0) ? lock0 : lock1)) owner = -1;
      end else if (g >= 0) begin
        last = (g == 1);
        if ((g == 0) ? lock0 : lock1) owner = g;
      end
    end
    for (int i = 0; i < 2; i++) begin
      pa[i] = adr_o[i];
      pw[i] = wren[i];
      pd[i] = data_o[i];
    end
    cyc++;
  endtask

  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic l0,
                      input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic q1, input logic w1, input logic l1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    qp0 = ram[0][pa[0]];
    if (pw[0]) ram[0][pa[0]] = pd[0];
    qp1[2] = qp1[1];
    qp1[1] = qp1[0];
    qp1[0] = ram[1][pa[1]];
    if (pw[1]) ram[1][pa[1]] = pd[1];
    rst_n = r;
    req0 = q0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = q1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    #1;
    model_check();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ram[0][a] = d;
    ram[1][a] = d;
    ref_mem[a] = d;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    qp0 = '0;
    for (int k = 0; k < 3; k++) qp1[k] = '0;
    for (int i = 0; i < 2; i++) begin
      pa[i] = '0; pw[i] = 1'b0; pd[i] = '0;
    end
    for (int a = 0; a < 4096; a++) preload(AW'(a), 32'(a) * 32'h0101_0101);
    preload(12'h004, 32'hDEAD_BEEF);
    preload(12'h020, 32'h1111_2222);
    preload(12'h030, 32'h3333_4444);
    preload(12'h060, 32'h6666_6666);
    preload(12'h001, 32'h0000_0A01);
    preload(12'h002, 32'h0000_0A02);
    preload(12'h003, 32'h0000_0A03);

    tbl[0]  = mk(1, 1,0,0,12'h004,0,            0,0,0,12'h000,0,     1,0,0,0,0);
    tbl[1]  = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,0,0,0);
    tbl[2]  = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,1,0,32'hDEAD_BEEF);
    tbl[3]  = mk(0, 1,0,0,12'h020,0,            1,0,0,12'h030,0,     0,0,0,0,0);
    tbl[4]  = mk(1, 1,0,0,12'h020,0,            1,0,0,12'h030,0,     1,0,0,0,0);
    tbl[5]  = mk(1, 1,0,0,12'h020,0,            1,0,0,12'h030,0,     0,1,0,0,0);
    tbl[6]  = mk(1, 1,0,0,12'h020,0,            1,0,0,12'h030,0,     1,0,1,0,32'h1111_2222);
    tbl[7]  = mk(1, 1,0,0,12'h020,0,            1,0,0,12'h030,0,     0,1,0,1,32'h3333_4444);
    tbl[8]  = mk(1, 1,1,0,12'h050,32'h5555,     0,0,0,12'h000,0,     1,0,1,0,32'h1111_2222);
    tbl[9]  = mk(1, 1,0,0,12'h060,0,            1,1,1,12'h010,32'hAA, 0,1,0,1,32'h3333_4444);
    tbl[10] = mk(1, 1,0,0,12'h060,0,            1,0,0,12'h010,0,     0,1,0,0,0);
    tbl[11] = mk(1, 1,0,0,12'h060,0,            0,0,0,12'h000,0,     1,0,0,0,0);
    tbl[12] = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,0,1,32'h0000_00AA);
    tbl[13] = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,1,0,32'h6666_6666);
    tbl[14] = mk(1, 1,0,0,12'h004,0,            0,0,0,12'h000,0,     1,0,0,0,0);
    tbl[15] = mk(0, 1,0,0,12'h004,0,            1,0,0,12'h030,0,     0,0,0,0,0);
    tbl[16] = mk(1, 1,0,0,12'h004,0,            1,0,0,12'h030,0,     1,0,0,0,0);
    tbl[17] = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,0,0,0);
    tbl[18] = mk(1, 0,0,0,12'h000,0,            0,0,0,12'h000,0,     0,0,1,0,32'hDEAD_BEEF);

    step(1'b0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    step(1'b0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);

    for (int k = 0; k < 19; k++) begin
      step(tbl[k].rst, tbl[k].q0, tbl[k].w0, tbl[k].l0, tbl[k].a0, tbl[k].d0,
           tbl[k].q1, tbl[k].w1, tbl[k].l1, tbl[k].a1, tbl[k].d1);
      chk($sformatf("tbl%0d_gnt0", k), 64'(gnt0[0]), 64'(tbl[k].eg0));
      chk($sformatf("tbl%0d_gnt1", k), 64'(gnt1[0]), 64'(tbl[k].eg1));
      chk($sformatf("tbl%0d_rvalid0", k), 64'(rvalid0[0]), 64'(tbl[k].erv0));
      chk($sformatf("tbl%0d_rvalid1", k), 64'(rvalid1[0]), 64'(tbl[k].erv1));
      if (tbl[k].erv0) chk($sformatf("tbl%0d_rdata0", k), 64'(rdata0[0]), 64'(tbl[k].erd));
      if (tbl[k].erv1) chk($sformatf("tbl%0d_rdata1", k), 64'(rdata1[0]), 64'(tbl[k].erd));
    end

    // Three back-to-back reads on the latency-3 instance.
    idle(4);
    for (int k = 0; k < 8; k++) begin
      if (k < 3) step(1'b1, 1, 0, 0, AW'(k + 1), '0, 0, 0, 0, '0, '0);
      else       idle(1);
      obs_v[k] = rvalid0[1];
      obs_d[k] = rdata0[1];
    end
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("lat3_rvalid0_c%0d", k), 64'(obs_v[k]), 64'(k >= 4 && k <= 6));
      if (k >= 4 && k <= 6)
        chk($sformatf("lat3_rdata0_c%0d", k), 64'(obs_d[k]), 64'(32'h0000_0A00 + 32'(k - 3)));
    end

    // Port 0 lock released in a cycle with no grant; port 1 waits throughout.
    step(1'b1, 1, 0, 1, 12'h005, '0, 0, 0, 0, '0, '0);
    chk("lk0_gnt0_c0", 64'(gnt0[0]), 64'd1);
    step(1'b1, 0, 0, 1, '0, '0, 1, 1, 0, 12'h007, 32'h77);
    chk("lk0_gnt1_c1", 64'(gnt1[0]), 64'd0);
    step(1'b1, 0, 0, 0, '0, '0, 1, 1, 0, 12'h007, 32'h77);
    chk("lk0_gnt1_c2", 64'(gnt1[0]), 64'd0);
    step(1'b1, 0, 0, 0, '0, '0, 1, 1, 0, 12'h007, 32'h77);
    chk("lk0_gnt1_c3", 64'(gnt1[0]), 64'd1);
    chk("lk0_wren_c3", 64'(wren[0]), 64'd1);
    idle(5);

    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 15)), $urandom(),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 15)), $urandom());
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
